// File: rtl/car_pkg.sv
// Shared widths, coefficient record layout and sequencer state encoding for the CAR channel sequencer.
package car_pkg;

    localparam int CAR_DATA_W   = 31;
    localparam int CAR_PARA_W   = 9;
    localparam int CAR_NUM_PARA = 5;

    typedef struct packed {
        logic [CAR_PARA_W-1:0] a0;
        logic [CAR_PARA_W-1:0] c0;
        logic [CAR_PARA_W-1:0] r;
        logic [CAR_PARA_W-1:0] g;
        logic [CAR_PARA_W-1:0] h;
    } car_para_t;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_ISSUE = 3'd2,
        SEQ_WAIT  = 3'd3,
        SEQ_EMIT  = 3'd4
    } car_seq_state_e;

    // Index width that stays at least one bit for single-entry configurations.
    function automatic int car_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/car_channel_sequencer_if.sv
// Request/result handshake between the sequencer (master) and the external CAR compute unit (slave).
interface car_channel_sequencer_if #(
    parameter int DATA_W = car_pkg::CAR_DATA_W,
    parameter int PARA_W = car_pkg::CAR_PARA_W
);
    logic [DATA_W-1:0]                       car_x_o;
    logic [DATA_W-1:0]                       car_z1_o;
    logic [DATA_W-1:0]                       car_z2_o;
    logic [car_pkg::CAR_NUM_PARA*PARA_W-1:0] car_para_o;
    logic                                    car_valid_o;
    logic                                    car_ready_i;
    logic [DATA_W-1:0]                       car_y_i;
    logic [DATA_W-1:0]                       car_z1_i;
    logic [DATA_W-1:0]                       car_z2_i;
    logic                                    car_valid_i;
    logic                                    car_ready_o;

    modport master (
        output car_x_o, car_z1_o, car_z2_o, car_para_o, car_valid_o, car_ready_o,
        input  car_ready_i, car_y_i, car_z1_i, car_z2_i, car_valid_i
    );

    modport slave (
        input  car_x_o, car_z1_o, car_z2_o, car_para_o, car_valid_o, car_ready_o,
        output car_ready_i, car_y_i, car_z1_i, car_z2_i, car_valid_i
    );
endinterface

// File: rtl/car_state_mem.sv
// Per-channel z1/z2 filter state: one write port, asynchronous read, cleared by reset.
// Write takes effect on the next rising edge; no backpressure.
module car_state_mem #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_W      = 31,
    parameter int ADDR_W      = 3
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] z1_wdat_i,
    input  logic [DATA_W-1:0] z2_wdat_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] z1_rdat_o,
    output logic [DATA_W-1:0] z2_rdat_o
);
    logic [DATA_W-1:0] z1_q [NUM_ENTRIES];
    logic [DATA_W-1:0] z2_q [NUM_ENTRIES];
    logic [DATA_W-1:0] z1_d [NUM_ENTRIES];
    logic [DATA_W-1:0] z2_d [NUM_ENTRIES];

    always_comb begin
        z1_d = z1_q;
        z2_d = z2_q;
        if (we_i) begin
            z1_d[waddr_i] = z1_wdat_i;
            z2_d[waddr_i] = z2_wdat_i;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                z1_q[i] <= '0;
                z2_q[i] <= '0;
            end
        end else begin
            z1_q <= z1_d;
            z2_q <= z2_d;
        end
    end

    assign z1_rdat_o = z1_q[raddr_i];
    assign z2_rdat_o = z2_q[raddr_i];
endmodule

// File: rtl/car_channel_sequencer.sv
// Walks one sample through NUM_CHANNELS cascaded CAR stages on an external compute unit; request 2 cycles after accept.
// Each handshake stalls until its partner is ready; define CAR_TIMEOUT_EN for a sticky WAIT watchdog.
module car_channel_sequencer
    import car_pkg::*;
#(
    parameter int NUM_CHANNELS            = 8,
    parameter int NUM_BIT_RESOLUTION_DATA = CAR_DATA_W,
    parameter int NUM_BIT_RESOLUTION_PARA = CAR_PARA_W,
    parameter int TIMEOUT_CYCLES          = 64
) (
    input  logic                                              clk,
    input  logic                                              rst_i,
    input  logic                                              sample_valid_i,
    output logic                                              sample_ready_o,
    input  logic [NUM_BIT_RESOLUTION_DATA-1:0]                sample_i,
    output logic [car_idx_w(NUM_CHANNELS)-1:0]                para_addr_o,
    input  logic [CAR_NUM_PARA*NUM_BIT_RESOLUTION_PARA-1:0]   para_i,
    car_channel_sequencer_if.master                           car,
    output logic [NUM_BIT_RESOLUTION_DATA-1:0]                y_o,
    output logic [car_idx_w(NUM_CHANNELS)-1:0]                ch_o,
    output logic                                              y_valid_o,
    input  logic                                              y_ready_i,
    output logic                                              busy_o,
    output logic                                              error_o
);
    localparam int DW     = NUM_BIT_RESOLUTION_DATA;
    localparam int PBW    = CAR_NUM_PARA * NUM_BIT_RESOLUTION_PARA;
    localparam int CH_W   = car_idx_w(NUM_CHANNELS);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    car_seq_state_e  state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [DW-1:0]   x_q, x_d;
    logic [DW-1:0]   y_q, y_d;
    logic [DW-1:0]   car_x_q, car_x_d;
    logic [DW-1:0]   car_z1_q, car_z1_d;
    logic [DW-1:0]   car_z2_q, car_z2_d;
    logic [PBW-1:0]  car_para_q, car_para_d;
    logic            mem_we;
    logic [DW-1:0]   mem_z1_rd, mem_z2_rd;

`ifdef CAR_TIMEOUT_EN
    localparam int TMO_W = car_idx_w(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             error_q, error_d;
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        x_d        = x_q;
        y_d        = y_q;
        car_x_d    = car_x_q;
        car_z1_d   = car_z1_q;
        car_z2_d   = car_z2_q;
        car_para_d = car_para_q;
        mem_we     = 1'b0;
`ifdef CAR_TIMEOUT_EN
        tmo_cnt_d  = '0;
        error_d    = error_q;
`endif
        case (state_q)
            SEQ_IDLE: begin
                if (sample_valid_i) begin
                    x_d     = sample_i;
                    ch_d    = '0;
                    state_d = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                car_x_d    = x_q;
                car_z1_d   = mem_z1_rd;
                car_z2_d   = mem_z2_rd;
                car_para_d = para_i;
                state_d    = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                if (car.car_ready_i) state_d = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                if (car.car_valid_i) begin
                    mem_we  = 1'b1;
                    y_d     = car.car_y_i;
                    state_d = SEQ_EMIT;
                end
`ifdef CAR_TIMEOUT_EN
                // Abandon the sample: state memory keeps its previous contents.
                else if (tmo_cnt_q == TMO_LAST) begin
                    error_d = 1'b1;
                    ch_d    = '0;
                    state_d = SEQ_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            SEQ_EMIT: begin
                if (y_ready_i) begin
                    if (ch_q == LAST_CH) begin
                        ch_d    = '0;
                        state_d = SEQ_IDLE;
                    end else begin
                        // Cascade: this channel's output is the next channel's input.
                        ch_d    = ch_q + CH_W'(1);
                        x_d     = y_q;
                        state_d = SEQ_FETCH;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SEQ_IDLE;
            ch_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            car_x_q    <= '0;
            car_z1_q   <= '0;
            car_z2_q   <= '0;
            car_para_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            x_q        <= x_d;
            y_q        <= y_d;
            car_x_q    <= car_x_d;
            car_z1_q   <= car_z1_d;
            car_z2_q   <= car_z2_d;
            car_para_q <= car_para_d;
        end
    end

`ifdef CAR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            error_q   <= error_d;
        end
    end
    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    car_state_mem #(
        .NUM_ENTRIES (NUM_CHANNELS),
        .DATA_W      (DW),
        .ADDR_W      (CH_W)
    ) u_state_mem (
        .clk       (clk),
        .rst_i     (rst_i),
        .we_i      (mem_we),
        .waddr_i   (ch_q),
        .z1_wdat_i (car.car_z1_i),
        .z2_wdat_i (car.car_z2_i),
        .raddr_i   (ch_q),
        .z1_rdat_o (mem_z1_rd),
        .z2_rdat_o (mem_z2_rd)
    );

    assign sample_ready_o  = (state_q == SEQ_IDLE);
    assign busy_o          = (state_q != SEQ_IDLE);
    assign para_addr_o     = ch_q;
    assign car.car_x_o     = car_x_q;
    assign car.car_z1_o    = car_z1_q;
    assign car.car_z2_o    = car_z2_q;
    assign car.car_para_o  = car_para_q;
    assign car.car_valid_o = (state_q == SEQ_ISSUE);
    assign car.car_ready_o = (state_q == SEQ_WAIT);
    assign y_o             = y_q;
    assign ch_o            = ch_q;
    assign y_valid_o       = (state_q == SEQ_EMIT);
endmodule

// File: tb/tb_car_channel_sequencer.sv
// Scoreboard bench: a behavioural compute unit answers requests, a sink drains the y stream against the model.
module tb_car_channel_sequencer;
    import car_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 31;
    localparam int PW  = 9;
    localparam int TMO = 8;
    localparam int CHW = 2;

    typedef struct packed {
        logic [DW-1:0]   x;
        logic [DW-1:0]   z1;
        logic [DW-1:0]   z2;
        logic [5*PW-1:0] para;
    } req_t;

    typedef struct packed {
        logic [CHW-1:0] ch;
        logic [DW-1:0]  y;
    } out_t;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            sample_valid_i = 1'b0;
    logic            sample_ready_o;
    logic [DW-1:0]   sample_i = '0;
    logic [CHW-1:0]  para_addr_o;
    logic [5*PW-1:0] para_i;
    logic [DW-1:0]   y_o;
    logic [CHW-1:0]  ch_o;
    logic            y_valid_o;
    logic            y_ready_i = 1'b0;
    logic            busy_o;
    logic            error_o;

    always #5 clk = ~clk;

    car_channel_sequencer_if #(.DATA_W(DW), .PARA_W(PW)) car_if ();

    car_channel_sequencer #(
        .NUM_CHANNELS            (NCH),
        .NUM_BIT_RESOLUTION_DATA (DW),
        .NUM_BIT_RESOLUTION_PARA (PW),
        .TIMEOUT_CYCLES          (TMO)
    ) dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .sample_i       (sample_i),
        .para_addr_o    (para_addr_o),
        .para_i         (para_i),
        .car            (car_if),
        .y_o            (y_o),
        .ch_o           (ch_o),
        .y_valid_o      (y_valid_o),
        .y_ready_i      (y_ready_i),
        .busy_o         (busy_o),
        .error_o        (error_o)
    );

    car_para_t para_tbl [NCH];
    assign para_i = para_tbl[para_addr_o];

    int   n_vec = 0;
    int   n_err = 0;
    int   n_y   = 0;
    req_t q_req [$];
    out_t q_out [$];
    logic [DW-1:0] mz1 [NCH];
    logic [DW-1:0] mz2 [NCH];
    bit   silent = 1'b0;
    bit   spurious = 1'b0;
    int   car_stall = 0;
    int   y_stall = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural compute unit shared by the responder and the expectation model.
    function automatic void car_model(input logic [DW-1:0] x, input logic [DW-1:0] z1,
                                      input logic [DW-1:0] z2, input car_para_t p,
                                      output logic [DW-1:0] y, output logic [DW-1:0] z1n,
                                      output logic [DW-1:0] z2n);
        y   = $signed(x) >>> 1;
        y   = y + z2 + DW'(5);
        z1n = x + y;
        z2n = z1 + DW'(p.h);
    endfunction

    task automatic push_expect(input logic [DW-1:0] x0, input bit no_resp);
        logic [DW-1:0] x, y, z1n, z2n;
        req_t r;
        out_t o;
        x = x0;
        for (int c = 0; c < NCH; c++) begin
            r.x = x; r.z1 = mz1[c]; r.z2 = mz2[c]; r.para = para_tbl[c];
            q_req.push_back(r);
            if (no_resp) return;
            car_model(x, mz1[c], mz2[c], para_tbl[c], y, z1n, z2n);
            o.ch = CHW'(c); o.y = y;
            q_out.push_back(o);
            mz1[c] = z1n;
            mz2[c] = z2n;
            x = y;
        end
    endtask

    initial begin : responder
        logic          pending;
        logic [DW-1:0] ry, rz1, rz2;
        int            stall_cnt;
        req_t          r;
        pending = 1'b0; stall_cnt = 0;
        ry = '0; rz1 = '0; rz2 = '0;
        car_if.car_valid_i = 1'b0; car_if.car_ready_i = 1'b0;
        car_if.car_y_i = '0; car_if.car_z1_i = '0; car_if.car_z2_i = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                pending = 1'b0; stall_cnt = 0;
                car_if.car_valid_i = 1'b0; car_if.car_ready_i = 1'b0;
            end else begin
                car_if.car_valid_i = pending | spurious;
                car_if.car_y_i  = pending ? ry  : DW'($urandom());
                car_if.car_z1_i = pending ? rz1 : DW'($urandom());
                car_if.car_z2_i = pending ? rz2 : DW'($urandom());
                if (pending && car_if.car_ready_o) pending = 1'b0;
                if (car_if.car_valid_o) begin
                    if (q_req.size() == 0) begin
                        chk("req_extra", car_if.car_valid_o, 0);
                        car_if.car_ready_i = 1'b1;
                    end else begin
                        r = q_req[0];
                        chk("req_x", car_if.car_x_o, r.x);
                        chk("req_z1", car_if.car_z1_o, r.z1);
                        chk("req_z2", car_if.car_z2_o, r.z2);
                        chk("req_para", car_if.car_para_o, r.para);
                        car_if.car_ready_i = (stall_cnt >= car_stall);
                        if (car_if.car_ready_i) begin
                            void'(q_req.pop_front());
                            car_model(car_if.car_x_o, car_if.car_z1_o, car_if.car_z2_o,
                                      car_para_t'(car_if.car_para_o), ry, rz1, rz2);
                            pending = !silent;
                            stall_cnt = 0;
                        end else begin
                            stall_cnt++;
                        end
                    end
                end else begin
                    car_if.car_ready_i = 1'b0;
                end
            end
        end
    end

    initial begin : y_sink
        int   ystall_cnt;
        int   gap;
        out_t o;
        ystall_cnt = 0; gap = 0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                y_ready_i = 1'b0; ystall_cnt = 0; gap = 0;
            end else begin
                if (gap == 2) begin
                    chk("gap_fetch", car_if.car_valid_o, 0);
                    gap = 1;
                end else if (gap == 1) begin
                    chk("gap_issue", car_if.car_valid_o, 1);
                    gap = 0;
                end
                if (y_valid_o) begin
                    if (q_out.size() == 0) begin
                        chk("y_extra", y_valid_o, 0);
                        y_ready_i = 1'b1;
                    end else begin
                        o = q_out[0];
                        chk("y_ch", ch_o, o.ch);
                        chk("y_dat", y_o, o.y);
                        y_ready_i = (ystall_cnt >= y_stall);
                        if (y_ready_i) begin
                            void'(q_out.pop_front());
                            n_y++;
                            ystall_cnt = 0;
                            if (o.ch != CHW'(NCH - 1)) gap = 2;
                        end else begin
                            ystall_cnt++;
                        end
                    end
                end else begin
                    y_ready_i = 1'b0;
                end
            end
        end
    end

    // Caller sits on a negedge; returns on the negedge where the request is first offered.
    task automatic send_sample(input logic [DW-1:0] x, input bit junk);
        int k;
        push_expect(x, silent);
        sample_valid_i = 1'b1;
        sample_i = x;
        k = 0;
        while (!sample_ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("accept", sample_ready_o, 1);
        @(negedge clk);
        chk("fetch_no_req", car_if.car_valid_o, 0);
        chk("fetch_busy", busy_o, 1);
        chk("fetch_not_rdy", sample_ready_o, 0);
        if (junk) sample_i = DW'($urandom());
        else sample_valid_i = 1'b0;
        @(negedge clk);
        chk("issue_latency", car_if.car_valid_o, 1);
        if (junk) begin
            repeat (2) @(negedge clk);
            sample_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(sample_ready_o && q_out.size() == 0) && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("idle_rdy", sample_ready_o, 1);
        chk("idle_busy", busy_o, 0);
        chk("outs_left", q_out.size(), 0);
    endtask

    task automatic wait_in_wait();
        int k = 0;
        while (!car_if.car_ready_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("enter_wait", car_if.car_ready_o, 1);
    endtask

    task automatic run_sample(input logic [DW-1:0] x, input bit junk);
        int n0;
        n0 = n_y;
        send_sample(x, junk);
        wait_idle();
        chk("y_pulses", n_y - n0, NCH);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        para_tbl[0] = '{a0: 9'hD8, c0: 9'h89, r: 9'hF1, g: 9'h85, h: 9'h89};
        para_tbl[1] = '{a0: 9'h1A3, c0: 9'h044, r: 9'h0F0, g: 9'h10F, h: 9'h033};
        para_tbl[2] = '{a0: 9'h055, c0: 9'h1FF, r: 9'h001, g: 9'h0AA, h: 9'h17E};
        para_tbl[3] = '{a0: 9'h100, c0: 9'h0C3, r: 9'h19A, g: 9'h002, h: 9'h0D5};
        for (int c = 0; c < NCH; c++) begin
            mz1[c] = '0;
            mz2[c] = '0;
        end

        repeat (3) @(negedge clk);
        chk("rst_sample_rdy", sample_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_car_valid", car_if.car_valid_o, 0);
        chk("rst_car_ready", car_if.car_ready_o, 0);
        chk("rst_y_valid", y_valid_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_car_x", car_if.car_x_o, 0);
        chk("rst_car_para", car_if.car_para_o, 0);
        chk("rst_y", y_o, 0);
        chk("rst_ch", ch_o, 0);
        chk("rst_para_addr", para_addr_o, 0);
        rst_i = 1'b0;
        @(negedge clk);

        // 1.0 through the cascade: channel 0 answers 0x085, which feeds channel 1.
        run_sample(DW'('h100), 1'b0);

        // Back-pressure on both handshakes plus a sample offered while busy.
        car_stall = 5;
        y_stall = 3;
        run_sample(DW'($urandom()), 1'b1);
        car_stall = 0;
        y_stall = 0;

        // Stray results while idle must not disturb anything.
        spurious = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("spur_no_y", y_valid_o, 0);
        end
        spurious = 1'b0;
        @(negedge clk);
        run_sample(DW'($urandom()), 1'b0);

        // Compute unit goes silent.
        silent = 1'b1;
        send_sample(DW'($urandom()), 1'b0);
        wait_in_wait();
`ifdef CAR_TIMEOUT_EN
        begin
            int n = 0;
            while (car_if.car_ready_o && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk("tmo_wait_cycles", n, TMO);
        end
        chk("tmo_error", error_o, 1);
        chk("tmo_idle", sample_ready_o, 1);
        chk("tmo_no_y", y_valid_o, 0);
        silent = 1'b0;
        run_sample(DW'($urandom()), 1'b0);
        chk("err_sticky", error_o, 1);
        silent = 1'b1;
        send_sample(DW'($urandom()), 1'b0);
        wait_in_wait();
        repeat (3) @(negedge clk);
`else
        repeat (12) @(negedge clk);
        chk("hold_wait", car_if.car_ready_o, 1);
        chk("hold_busy", busy_o, 1);
        chk("hold_no_err", error_o, 0);
        chk("hold_no_y", y_valid_o, 0);
`endif
        chk("req_left_silent", q_req.size(), 0);

        // Reset while waiting on the compute unit.
        rst_i = 1'b1;
        #1;
        chk("midrst_rdy", sample_ready_o, 1);
        chk("midrst_car_ready", car_if.car_ready_o, 0);
        chk("midrst_y_valid", y_valid_o, 0);
        chk("midrst_error", error_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        silent = 1'b0;
        q_req.delete();
        q_out.delete();
        for (int c = 0; c < NCH; c++) begin
            mz1[c] = '0;
            mz2[c] = '0;
        end
        @(negedge clk);
        chk("post_rst_idle", sample_ready_o, 1);

        // Cleared state memory shows up as zero z1/z2 operands again.
        run_sample(DW'('h100), 1'b0);
        run_sample(DW'($urandom()), 1'b0);
        chk("req_left_end", q_req.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
